// File: rtl/vcxo_lock_supervisor.sv
// vcxo_lock_supervisor: sequences the VCXO frequency-lock loop through acquire/lock/holdover/fault
// and schedules host corrections onto measurement boundaries.
// Optional: define LOCK_STATS_EN to add the lock_loss_cnt output.
module vcxo_lock_supervisor #(
  parameter int LOCK_WIN     = 20,
  parameter int UNLOCK_WIN   = 100,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 3,
  parameter int RAIL_COUNT   = 16,
  parameter int PWM_MAX      = 1000,
  parameter int WD_TIMEOUT   = 262144
) (
  input  logic               tcxo_clk_in,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               meas_valid,
  input  logic signed [23:0] freq_error,
  input  logic signed [23:0] pwm,
  input  logic signed [7:0]  corr_in,
  input  logic               corr_wr,
  input  logic               fault_clr,
  output logic signed [7:0]  VCXO_correction,
  output logic               corr_pending,
  output logic               locked,
  output logic               holdover,
  output logic               fault,
  output logic [2:0]         state_out
`ifdef LOCK_STATS_EN
  ,
  output logic [15:0]        lock_loss_cnt
`endif
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int RW = $clog2(RAIL_COUNT + 1);
  localparam int WW = $clog2(WD_TIMEOUT + 1);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACQUIRE  = 3'd1,
    LOCKED   = 3'd2,
    HOLDOVER = 3'd3,
    FAULT    = 3'd4
  } state_t;
  state_t             state;
  logic signed [7:0]  pending;
  logic [GW-1:0]      good_cnt, g_next;
  logic [BW-1:0]      bad_cnt, b_next;
  logic [RW-1:0]      rail_cnt, r_next;
  logic [WW-1:0]      wd_cnt, wd_next;
  logic [23:0]        abs_err;
  logic               rail_trip, wd_trip, apply_now;
  assign state_out = state;
  // per-sample evaluation: saturating abs error and next counter values
  always_comb begin
    abs_err   = freq_error == 24'sh800000 ? 24'h7fffff :
                freq_error[23] ? $unsigned(-freq_error) : $unsigned(freq_error);
    g_next    = abs_err <= 24'(LOCK_WIN) ?
                (good_cnt == GW'(LOCK_COUNT) ? good_cnt : good_cnt + GW'(1)) : '0;
    b_next    = abs_err > 24'(UNLOCK_WIN) ?
                (bad_cnt == BW'(UNLOCK_COUNT) ? bad_cnt : bad_cnt + BW'(1)) : '0;
    r_next    = (pwm <= 24'sd0 || pwm >= 24'(PWM_MAX)) ?
                (rail_cnt == RW'(RAIL_COUNT) ? rail_cnt : rail_cnt + RW'(1)) : '0;
    wd_next   = wd_cnt == WW'(WD_TIMEOUT) ? wd_cnt : wd_cnt + WW'(1);
    rail_trip = r_next == RW'(RAIL_COUNT);
    wd_trip   = wd_next == WW'(WD_TIMEOUT);
    apply_now = corr_pending && ((state inside {IDLE, FAULT, HOLDOVER}) ||
                (meas_valid && (state inside {ACQUIRE, LOCKED})));
  end
  // supervisor FSM with registered flags, counters and correction scheduling
  always_ff @(posedge tcxo_clk_in or negedge reset_n)
    if (!reset_n) begin
      state           <= IDLE;
      locked          <= 1'b0;
      holdover        <= 1'b0;
      fault           <= 1'b0;
      VCXO_correction <= '0;
      pending         <= '0;
      corr_pending    <= 1'b0;
      good_cnt        <= '0;
      bad_cnt         <= '0;
      rail_cnt        <= '0;
      wd_cnt          <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      locked   <= 1'b0;
      holdover <= 1'b0;
      fault    <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      rail_cnt <= '0;
      wd_cnt   <= '0;
      if (corr_wr) begin
        pending      <= corr_in;
        corr_pending <= 1'b1;
      end
    end else begin
      if (apply_now) begin
        VCXO_correction <= pending;
        corr_pending    <= 1'b0;
      end
      if (corr_wr) begin
        pending      <= corr_in;
        corr_pending <= 1'b1;
      end
      case (state)
        IDLE: state <= ACQUIRE;
        ACQUIRE, LOCKED:
          if (meas_valid) begin
            wd_cnt   <= '0;
            rail_cnt <= r_next;
            if (rail_trip) begin
              state  <= FAULT;
              fault  <= 1'b1;
              locked <= 1'b0;
            end else if (corr_pending) begin
              state    <= ACQUIRE;
              locked   <= 1'b0;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else if (state == ACQUIRE) begin
              good_cnt <= g_next;
              if (g_next == GW'(LOCK_COUNT)) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                bad_cnt <= '0;
              end
            end else begin
              bad_cnt <= b_next;
              if (b_next == BW'(UNLOCK_COUNT)) begin
                state    <= ACQUIRE;
                locked   <= 1'b0;
                good_cnt <= '0;
              end
            end
          end else begin
            wd_cnt <= wd_next;
            if (wd_trip) begin
              state    <= HOLDOVER;
              holdover <= 1'b1;
              locked   <= 1'b0;
            end
          end
        HOLDOVER:
          if (meas_valid) begin
            state    <= ACQUIRE;
            holdover <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            rail_cnt <= '0;
            wd_cnt   <= '0;
          end
        FAULT:
          if (fault_clr) begin
            state    <= IDLE;
            fault    <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            rail_cnt <= '0;
            wd_cnt   <= '0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef LOCK_STATS_EN
  logic lock_drop;
  assign lock_drop = enable && state == LOCKED &&
                     (meas_valid ? !rail_trip && (corr_pending || b_next == BW'(UNLOCK_COUNT)) : wd_trip);
  // counts every exit from LOCKED into ACQUIRE or HOLDOVER, saturating
  always_ff @(posedge tcxo_clk_in or negedge reset_n)
    if (!reset_n) lock_loss_cnt <= '0;
    else if (lock_drop && lock_loss_cnt != 16'hffff) lock_loss_cnt <= lock_loss_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vcxo_lock_supervisor.sv
// tb_vcxo_lock_supervisor: directed scoreboard bench for vcxo_lock_supervisor (short watchdog timeout)
module tb_vcxo_lock_supervisor;
  localparam int WD = 300;
  logic               tcxo_clk_in = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               meas_valid = 1'b0;
  logic signed [23:0] freq_error = '0;
  logic signed [23:0] pwm = '0;
  logic signed [7:0]  corr_in = '0;
  logic               corr_wr = 1'b0;
  logic               fault_clr = 1'b0;
  logic signed [7:0]  VCXO_correction;
  logic               corr_pending, locked, holdover, fault;
  logic [2:0]         state_out;
`ifdef LOCK_STATS_EN
  logic [15:0]        lock_loss_cnt;
`endif
  typedef struct {
    int          cyc;
    logic [14:0] v;
  } exp_t;
  exp_t  q[$];
  string nq[$];
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;
  vcxo_lock_supervisor #(.WD_TIMEOUT(WD)) dut (
    .tcxo_clk_in(tcxo_clk_in), .reset_n(reset_n), .enable(enable), .meas_valid(meas_valid),
    .freq_error(freq_error), .pwm(pwm), .corr_in(corr_in), .corr_wr(corr_wr), .fault_clr(fault_clr),
    .VCXO_correction(VCXO_correction), .corr_pending(corr_pending), .locked(locked),
    .holdover(holdover), .fault(fault), .state_out(state_out)
`ifdef LOCK_STATS_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );
  always #5 tcxo_clk_in = ~tcxo_clk_in;
  always @(posedge tcxo_clk_in) cyc <= cyc + 1;
  // monitor: pops expectations due for this cycle and compares away from the active edge
  always @(negedge tcxo_clk_in) begin
    logic [14:0] got;
    got = {state_out, locked, holdover, fault, VCXO_correction, corr_pending};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = q.pop_front();
      nm = nq.pop_front();
      nvec++;
      if (got !== e.v) begin
        nerr++;
        $display("FAIL %s cyc %0d: got st=%0d lk=%b ho=%b ft=%b corr=%0d cp=%b, want st=%0d lk=%b ho=%b ft=%b corr=%0d cp=%b",
                 nm, cyc, got[14:12], got[11], got[10], got[9], $signed(got[8:1]), got[0],
                 e.v[14:12], e.v[11], e.v[10], e.v[9], $signed(e.v[8:1]), e.v[0]);
      end
    end
  end
  task automatic step(input string nm, input logic en, input logic mv, input int fe, input int pw,
                      input logic cw, input int ci, input logic fc,
                      input logic [2:0] st, input logic lk, input logic ho, input logic ft,
                      input int corr, input logic cp);
    exp_t e;
    @(negedge tcxo_clk_in);
    enable = en; meas_valid = mv; freq_error = 24'(fe); pwm = 24'(pw);
    corr_wr = cw; corr_in = 8'(ci); fault_clr = fc;
    e.cyc = cyc + 1;
    e.v = {st, lk, ho, ft, 8'(corr), cp};
    q.push_back(e);
    nq.push_back(nm);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    int fa[7] = '{5, -5, 20, -20, 0, 5, 5};
    int ua[6] = '{150, 150, 100, -150, 150, -8388608};
    step("reset", 0,0,0,0,0,0,0, 3'd0,0,0,0, 0,0);
    step("reset", 0,0,0,0,0,0,0, 3'd0,0,0,0, 0,0);
    reset_n = 1'b1;
    step("idle_dis", 0,0,0,500,0,0,0, 3'd0,0,0,0, 0,0);
    step("acq_entry", 1,0,0,500,0,0,0, 3'd1,0,0,0, 0,0);
    for (int i = 0; i < 7; i++) step("acq_count", 1,1,fa[i],500,0,0,0, 3'd1,0,0,0, 0,0);
    step("win_edge21", 1,1,21,500,0,0,0, 3'd1,0,0,0, 0,0);
    for (int i = 1; i <= 8; i++) step("lock", 1,1,5,500,0,0,0, i == 8 ? 3'd2 : 3'd1, i == 8,0,0, 0,0);
    for (int i = 0; i < 6; i++) step("unlock", 1,1,ua[i],500,0,0,0, i == 5 ? 3'd1 : 3'd2, i != 5,0,0, 0,0);
    for (int i = 1; i <= 8; i++) step("relock", 1,1,0,500,0,0,0, i == 8 ? 3'd2 : 3'd1, i == 8,0,0, 0,0);
    for (int i = 1; i <= WD; i++) step("watchdog", 1,0,0,500,0,0,0, i == WD ? 3'd3 : 3'd2, i != WD, i == WD,0, 0,0);
    step("hold_stay", 1,0,0,500,0,0,0, 3'd3,0,1,0, 0,0);
    step("hold_exit", 1,1,5,500,0,0,0, 3'd1,0,0,0, 0,0);
    for (int i = 1; i <= 8; i++) step("reacq", 1,1,5,500,0,0,0, i == 8 ? 3'd2 : 3'd1, i == 8,0,0, 0,0);
    step("corr_wr1", 1,0,0,500,1,-12,0, 3'd2,1,0,0, 0,1);
    step("corr_wr2", 1,0,0,500,1,7,0, 3'd2,1,0,0, 0,1);
    step("corr_apply", 1,1,5,500,0,0,0, 3'd1,0,0,0, 7,0);
    step("corr_coinc", 1,1,5,500,1,3,0, 3'd1,0,0,0, 7,1);
    step("corr_apply2", 1,1,5,500,0,0,0, 3'd1,0,0,0, 3,0);
    for (int i = 1; i <= 8; i++) step("corr_relock", 1,1,5,500,0,0,0, i == 8 ? 3'd2 : 3'd1, i == 8,0,0, 3,0);
    step("disable", 0,0,0,500,0,0,0, 3'd0,0,0,0, 3,0);
    step("reenable", 1,0,0,500,0,0,0, 3'd1,0,0,0, 3,0);
    for (int i = 0; i < 5; i++) step("rail", 1,1,50,1000,0,0,0, 3'd1,0,0,0, 3,0);
    step("rail_999", 1,1,50,999,0,0,0, 3'd1,0,0,0, 3,0);
    for (int i = 0; i < 14; i++) step("rail", 1,1,50,1000,0,0,0, 3'd1,0,0,0, 3,0);
    step("rail_neg", 1,1,50,-5,0,0,0, 3'd1,0,0,0, 3,0);
    step("rail_trip", 1,1,50,0,0,0,0, 3'd4,0,0,1, 3,0);
    step("fault_mv", 1,1,5,500,0,0,0, 3'd4,0,0,1, 3,0);
    step("fault_corr", 1,0,0,500,1,-12,0, 3'd4,0,0,1, 3,1);
    step("fault_apply", 1,0,0,500,0,0,0, 3'd4,0,0,1, -12,0);
    step("fault_clr", 1,0,0,500,0,0,1, 3'd0,0,0,0, -12,0);
    step("restart", 1,0,0,500,0,0,0, 3'd1,0,0,0, -12,0);
    step("end", 1,0,0,500,0,0,0, 3'd1,0,0,0, -12,0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge tcxo_clk_in);
    #1;
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
